// File: rtl/port_merger_pkg.sv
// Shared hub constants and helpers for the port distributor/merger pair.
package port_merger_pkg;

    localparam int NUM_PORTS      = 4;
    localparam int BYTE_W         = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Round-robin pointer moves to the port just after the one served.
    function automatic logic [1:0] rr_after(input logic [1:0] granted);
        return granted + 2'd1;
    endfunction

endpackage

// File: rtl/port_merger_byte_fifo.sv
// Per-port byte buffer: registered storage, combinational head, wrap-bit pointers.
module byte_fifo
    import port_merger_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              wr_en;
    logic              rd_en;

    // A full buffer still takes a byte when its head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/port_merger.sv
// Four-port byte merger: per-port FIFOs, round-robin arbiter, registered output.
module port_merger
    import port_merger_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    input  logic [7:0]  din2,
    input  logic [7:0]  din3,
    input  logic        inv0,
    input  logic        inv1,
    input  logic        inv2,
    input  logic        inv3,
    output logic [7:0]  dout,
    output logic        outv,
    output logic [1:0]  src,
    output logic [3:0]  ovf
);

    logic [BYTE_W-1:0] din_v  [NUM_PORTS];
    logic [BYTE_W-1:0] head_v [NUM_PORTS];
    logic [3:0]        inv_v;
    logic [3:0]        full_v;
    logic [3:0]        empty_v;
    logic [3:0]        pop_v;
    logic [3:0]        ovf_set;
    logic [1:0]        rr_ptr;

    logic              vld_p0;
    logic [1:0]        gidx_p0;
    logic [1:0]        idx;

    assign din_v[0] = din0;
    assign din_v[1] = din1;
    assign din_v[2] = din2;
    assign din_v[3] = din3;
    assign inv_v    = {inv3, inv2, inv1, inv0};

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
        byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (inv_v[gi]),
            .pop   (pop_v[gi]),
            .din   (din_v[gi]),
            .dout  (head_v[gi]),
            .full  (full_v[gi]),
            .empty (empty_v[gi])
        );
    end

    // Stage 0: pick the first non-empty FIFO at or after rr_ptr.
    always_comb begin
        vld_p0  = 1'b0;
        gidx_p0 = rr_ptr;
        pop_v   = '0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr + 2'(k);
            if (!vld_p0 && !empty_v[idx]) begin
                vld_p0  = 1'b1;
                gidx_p0 = idx;
            end
        end
        pop_v[gidx_p0] = vld_p0;
    end

    assign ovf_set = inv_v & full_v & ~pop_v;

    // Stage 1: output register; dout/src hold when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout   <= '0;
            src    <= '0;
            outv   <= 1'b0;
            ovf    <= '0;
            rr_ptr <= '0;
        end else begin
            outv <= vld_p0;
            ovf  <= ovf | ovf_set;
            if (vld_p0) begin
                dout   <= head_v[gidx_p0];
                src    <= gidx_p0;
                rr_ptr <= rr_after(gidx_p0);
            end
        end
    end

endmodule

// File: tb/tb_port_merger.sv
// Bench for port_merger: directed table, corner sequences, random vs queue model.
module tb_port_merger;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] din0, din1, din2, din3;
    logic       inv0, inv1, inv2, inv3;
    logic [7:0] dout;
    logic       outv;
    logic [1:0] src;
    logic [3:0] ovf;

    port_merger #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .din0  (din0),
        .din1  (din1),
        .din2  (din2),
        .din3  (din3),
        .inv0  (inv0),
        .inv1  (inv1),
        .inv2  (inv2),
        .inv3  (inv3),
        .dout  (dout),
        .outv  (outv),
        .src   (src),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per port plus the round-robin pointer.
    logic [7:0] q [4][$];
    int         mrr;
    logic       m_outv;
    logic [7:0] m_dout;
    logic [1:0] m_src;
    logic [3:0] m_ovf;
    int         accepted;
    int         outv_cnt;

    typedef struct {
        logic [3:0]  inv;
        logic [31:0] d;
        logic        ev;
        logic [7:0]  edout;
        logic [1:0]  esrc;
        logic [3:0]  eovf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        mrr    = 0;
        m_outv = 1'b0;
        m_dout = 8'h00;
        m_src  = 2'd0;
        m_ovf  = 4'h0;
    endtask

    task automatic model_edge(input logic [3:0] v, input logic [31:0] d);
        int g = -1;
        for (int k = 0; k < 4; k++) begin
            int id = (mrr + k) % 4;
            if (g < 0 && q[id].size() > 0) g = id;
        end
        if (g >= 0) begin
            m_outv = 1'b1;
            m_dout = q[g].pop_front();
            m_src  = 2'(g);
            mrr    = (g + 1) % 4;
        end else begin
            m_outv = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            if (v[n]) begin
                if (q[n].size() < DEPTH) begin
                    q[n].push_back(d[8*n +: 8]);
                    accepted++;
                end else begin
                    m_ovf[n] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d);
        {inv3, inv2, inv1, inv0} = v;
        din0 = d[7:0];
        din1 = d[15:8];
        din2 = d[23:16];
        din3 = d[31:24];
    endtask

    task automatic cycle(input logic [3:0] v, input logic [31:0] d);
        @(negedge clk);
        drive(v, d);
        @(posedge clk);
        model_edge(v, d);
        #1;
        if (outv === 1'b1) outv_cnt++;
        chk("outv", 32'(outv), 32'(m_outv));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (m_outv) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("src", 32'(src), 32'(m_src));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(4'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rst_outv", 32'(outv), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(4'h0, 32'h0);
        model_reset();
        accepted = 0;
        outv_cnt = 0;

        // Two-port merge, then port 1 streaming six bytes.
        tbl[0]  = '{4'b0101, 32'h00C8_0070, 1'b0, 8'd0,   2'd0, 4'h0};
        tbl[1]  = '{4'b0000, 32'h0,         1'b1, 8'd112, 2'd0, 4'h0};
        tbl[2]  = '{4'b0000, 32'h0,         1'b1, 8'd200, 2'd2, 4'h0};
        tbl[3]  = '{4'b0000, 32'h0,         1'b0, 8'd200, 2'd2, 4'h0};
        tbl[4]  = '{4'b0010, 32'h0000_0100, 1'b0, 8'd200, 2'd2, 4'h0};
        tbl[5]  = '{4'b0010, 32'h0000_0200, 1'b1, 8'h01,  2'd1, 4'h0};
        tbl[6]  = '{4'b0010, 32'h0000_0300, 1'b1, 8'h02,  2'd1, 4'h0};
        tbl[7]  = '{4'b0010, 32'h0000_0400, 1'b1, 8'h03,  2'd1, 4'h0};
        tbl[8]  = '{4'b0010, 32'h0000_0500, 1'b1, 8'h04,  2'd1, 4'h0};
        tbl[9]  = '{4'b0010, 32'h0000_0600, 1'b1, 8'h05,  2'd1, 4'h0};
        tbl[10] = '{4'b0000, 32'h0,         1'b1, 8'h06,  2'd1, 4'h0};
        tbl[11] = '{4'b0000, 32'h0,         1'b0, 8'h06,  2'd1, 4'h0};

        #12;
        chk("init_outv", 32'(outv), 32'd0);
        chk("init_dout", 32'(dout), 32'd0);
        chk("init_src", 32'(src), 32'd0);
        chk("init_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].inv, tbl[i].d);
            chk($sformatf("tbl%0d_outv", i), 32'(outv), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].edout));
            chk($sformatf("tbl%0d_src", i), 32'(src), 32'(tbl[i].esrc));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].eovf));
        end

        // All ports flood for 8 cycles.
        do_reset();
        accepted = 0;
        outv_cnt = 0;
        for (int i = 0; i < 8; i++)
            cycle(4'hF, {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)});
        for (int i = 0; i < 20; i++) cycle(4'h0, 32'h0);
        chk("flood_ovf", 32'(ovf), 32'hF);
        chk("flood_outv_count", 32'(outv_cnt), 32'(accepted));

        // Full FIFO 3 pushed while granted: accepted, no overflow; then overflow when not granted.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(4'b1001, {8'hB0 + 8'(i), 16'h0, 8'hA0 + 8'(i)});
        cycle(4'b1000, 32'hB500_0000);
        cycle(4'b1000, 32'hB600_0000);
        chk("full_pop_src", 32'(src), 32'd3);
        chk("full_pop_ovf", 32'(ovf), 32'h0);
        cycle(4'b1000, 32'hB700_0000);
        chk("full_nopop_ovf", 32'(ovf), 32'h8);
        for (int i = 0; i < 10; i++) cycle(4'h0, 32'h0);

        // Reset mid-operation with FIFOs 0 and 2 holding data; inputs ignored during reset.
        do_reset();
        cycle(4'b0101, 32'h0022_0011);
        cycle(4'b0101, 32'h0044_0033);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_outv", 32'(outv), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        model_reset();
        @(negedge clk);
        drive(4'hF, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        drive(4'h0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(4'h0, 32'h0);
        chk("midrst_idle_outv", 32'(outv), 32'd0);
        cycle(4'b1010, 32'h7700_5500);
        cycle(4'h0, 32'h0);
        chk("midrst_first_src", 32'(src), 32'd1);
        chk("midrst_first_dout", 32'(dout), 32'h55);
        cycle(4'h0, 32'h0);
        cycle(4'h0, 32'h0);

        // Pointer wrap: after port 3 is served, port 0 wins a tie with port 3.
        do_reset();
        cycle(4'b1000, 32'h3A00_0000);
        cycle(4'h0, 32'h0);
        chk("wrap_g3_src", 32'(src), 32'd3);
        cycle(4'b1001, 32'h3C00_000B);
        cycle(4'h0, 32'h0);
        chk("wrap_first_src", 32'(src), 32'd0);
        chk("wrap_first_dout", 32'(dout), 32'h0B);
        cycle(4'h0, 32'h0);
        chk("wrap_second_src", 32'(src), 32'd3);
        chk("wrap_second_dout", 32'(dout), 32'h3C);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(4'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 20; i++) cycle(4'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
